// File: rtl/fma_arith_pkg.sv
// fma_arith_pkg
//   Shared arithmetic constants and helpers for the FMA datapath blocks.
//   SEG_DEFAULT / WIDTH_DEFAULT : default segment and operand widths
//   calc_nseg()                 : number of segments (= pipeline depth)
package fma_arith_pkg;

  localparam int SEG_DEFAULT   = 8;
  localparam int WIDTH_DEFAULT = 32;

  function automatic int calc_nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/seg_add_stage.sv
// seg_add_stage
//   One SEG-bit slice of the segmented adder: ripple add of a segment plus
//   carry-in, registered together with the slice valid bit.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     en              slice may load this cycle (from the enable chain)
//     in_valid        upstream slice / input holds a transaction
//     a_seg, b_seg    operand segments (b already inverted for subtract)
//     c_in            carry into this segment
//     valid_q         slice holds a transaction
//     sum_q, c_out_q  registered segment result and carry out
module seg_add_stage #(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           in_valid,
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           c_in,
  output logic           valid_q,
  output logic [SEG-1:0] sum_q,
  output logic           c_out_q
);

  logic           valid_d;
  logic [SEG-1:0] sum_d;
  logic           c_out_d;
  logic [SEG:0]   raw;

  always_comb begin
    raw     = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};
    valid_d = valid_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    if (en) begin
      valid_d = in_valid;
      // Data only moves with a real transaction so bubbles leave outputs quiet.
      if (in_valid) begin
        sum_d   = raw[SEG-1:0];
        c_out_d = raw[SEG];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

endmodule

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder
//   Segmented, pipelined WIDTH-bit adder/subtractor. Each pipeline stage adds
//   one SEG-bit segment; carry advances one segment per cycle. Upper operand
//   segments travel forward in skew registers, finished low result segments in
//   deskew registers. Valid/ready handshake on both sides, no skid buffer.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     in_valid, in_ready   input handshake
//     a, b, c_in, sub      operands; sub=1 computes a-b (c_in ignored)
//     out_valid, out_ready output handshake
//     sum, c_out, ovf      result, carry out of MSB, signed overflow
module seg_pipe_adder
  import fma_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SEG   = SEG_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSEG = calc_nseg(WIDTH, SEG);

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_param_check
    $fatal(1, "seg_pipe_adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic [NSEG-1:0] v;
  logic [NSEG-1:0] en;
  logic [NSEG-1:0] cy;
  logic [SEG-1:0]  seg_sum [NSEG];
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  assign b_eff   = sub ? ~b : b;
  assign c_first = sub ? 1'b1 : c_in;

  // en[k] = !v[k] || en[k+1] with en[NSEG] = out_ready, unrolled so every bit
  // depends only on the valid registers and out_ready.
  for (genvar k = 0; k < NSEG; k++) begin : g_en
    assign en[k] = out_ready || !(&v[NSEG-1:k]);
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int OPW = WIDTH - k*SEG;

    // op_a/op_b: operand segments k..NSEG-1 of the transaction entering stage k
    logic [OPW-1:0]       op_a;
    logic [OPW-1:0]       op_b;
    logic                 vin;
    logic                 cin;
    // done: result segments 0..k of the transaction held in stage k
    logic [(k+1)*SEG-1:0] done;

    if (k == 0) begin : g_head
      assign op_a = a;
      assign op_b = b_eff;
      assign vin  = in_valid;
      assign cin  = c_first;
    end else begin : g_body
      assign op_a = g_stg[k-1].g_skew.skew_a_q;
      assign op_b = g_stg[k-1].g_skew.skew_b_q;
      assign vin  = v[k-1];
      assign cin  = cy[k-1];
    end

    seg_add_stage #(.SEG(SEG)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en[k]),
      .in_valid (vin),
      .a_seg    (op_a[SEG-1:0]),
      .b_seg    (op_b[SEG-1:0]),
      .c_in     (cin),
      .valid_q  (v[k]),
      .sum_q    (seg_sum[k]),
      .c_out_q  (cy[k])
    );

    if (k < NSEG-1) begin : g_skew
      logic [OPW-SEG-1:0] skew_a_d, skew_a_q;
      logic [OPW-SEG-1:0] skew_b_d, skew_b_q;

      always_comb begin
        skew_a_d = skew_a_q;
        skew_b_d = skew_b_q;
        if (en[k] && vin) begin
          skew_a_d = op_a[OPW-1:SEG];
          skew_b_d = op_b[OPW-1:SEG];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          skew_a_q <= '0;
          skew_b_q <= '0;
        end else begin
          skew_a_q <= skew_a_d;
          skew_b_q <= skew_b_d;
        end
      end
    end

    if (k == 0) begin : g_lo0
      assign done = seg_sum[0];
    end else begin : g_dsk
      logic [k*SEG-1:0] lo_d, lo_q;

      always_comb begin
        lo_d = lo_q;
        if (en[k] && vin) lo_d = g_stg[k-1].done;
      end

      always_ff @(posedge clk) begin
        if (rst) lo_q <= '0;
        else     lo_q <= lo_d;
      end

      assign done = {seg_sum[k], lo_q};
    end

    // Sign bits of a and effective b captured alongside the top segment.
    if (k == NSEG-1) begin : g_tail
      logic a_msb_d, a_msb_q;
      logic b_msb_d, b_msb_q;

      always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        if (en[k] && vin) begin
          a_msb_d = op_a[OPW-1];
          b_msb_d = op_b[OPW-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_msb_q <= 1'b0;
          b_msb_q <= 1'b0;
        end else begin
          a_msb_q <= a_msb_d;
          b_msb_q <= b_msb_d;
        end
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v[NSEG-1];
  assign sum       = g_stg[NSEG-1].done;
  assign c_out     = cy[NSEG-1];
  assign ovf       = (g_stg[NSEG-1].g_tail.a_msb_q == g_stg[NSEG-1].g_tail.b_msb_q) &&
                     (sum[WIDTH-1] != g_stg[NSEG-1].g_tail.a_msb_q);

endmodule
